// File: rtl/loader_pkg.sv
// Shared types and sizes for the host input stream loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IFMAP,
    WEIGHT,
    BIAS
  } loader_state_t;

  localparam int DEF_IFMAP_WORDS  = 16;
  localparam int DEF_WEIGHT_WORDS = 1024;
  localparam int DEF_BIAS_WORDS   = 64;

  localparam int IFMAP_AW  = 5;
  localparam int WEIGHT_AW = 10;
  localparam int BIAS_AW   = 6;

  // Counter must index every segment and still feed the widest address.
  function automatic int cnt_width(int a, int b, int c);
    int m;
    int w;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    w = $clog2(m);
    return (w < WEIGHT_AW) ? WEIGHT_AW : w;
  endfunction

endpackage

// File: rtl/loader_addr_gen.sv
// Word counter for the loader with end-of-segment detect.
module loader_addr_gen #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [CNT_W-1:0] seg_end,
  output logic [CNT_W-1:0] cnt,
  output logic             seg_last
);

  assign seg_last = (cnt == seg_end);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (adv) begin
      cnt <= seg_last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stream_loader.sv
// Routes the ifmap/weight/bias input stream to the SRAM write ports.
// Optional checksum: define STREAM_LOADER_CHECKSUM_EN.
module stream_loader
  import loader_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int IFMAP_WORDS  = DEF_IFMAP_WORDS,
  parameter int WEIGHT_WORDS = DEF_WEIGHT_WORDS,
  parameter int BIAS_WORDS   = DEF_BIAS_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic                 ready,
  input  logic [DATA_W-1:0]    data_in,
  output logic                 busy,
  output logic                 ifmap_we,
  output logic [IFMAP_AW-1:0]  ifmap_addr,
  output logic                 weight_we,
  output logic [WEIGHT_AW-1:0] weight_addr,
  output logic                 bias_we,
  output logic [BIAS_AW-1:0]   bias_addr,
  output logic [DATA_W-1:0]    wdata,
  output logic                 load_done,
  output logic                 pass,
  output logic [DATA_W-1:0]    checksum
);

  localparam int CNT_W =
    cnt_width(IFMAP_WORDS, WEIGHT_WORDS, BIAS_WORDS);

  loader_state_t    state;
  loader_state_t    state_n;
  logic             start;
  logic             adv;
  logic             seg_last;
  logic             mode_q;
  logic             done_pend;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] seg_end;

  loader_addr_gen #(
    .CNT_W(CNT_W)
  ) u_addr (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .adv     (adv),
    .seg_end (seg_end),
    .cnt     (cnt),
    .seg_last(seg_last)
  );

  always_comb begin
    state_n = state;
    start   = 1'b0;
    adv     = 1'b0;
    seg_end = '0;
    unique case (state)
      IDLE: begin
        if (ready) begin
          state_n = IFMAP;
          start   = 1'b1;
        end
      end
      IFMAP: begin
        adv     = 1'b1;
        seg_end = CNT_W'(IFMAP_WORDS - 1);
        if (seg_last) state_n = WEIGHT;
      end
      WEIGHT: begin
        adv     = 1'b1;
        seg_end = CNT_W'(WEIGHT_WORDS - 1);
        if (seg_last) state_n = BIAS;
      end
      BIAS: begin
        adv     = 1'b1;
        seg_end = CNT_W'(BIAS_WORDS - 1);
        if (seg_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifmap_we    <= 1'b0;
      weight_we   <= 1'b0;
      bias_we     <= 1'b0;
      ifmap_addr  <= '0;
      weight_addr <= '0;
      bias_addr   <= '0;
      wdata       <= '0;
      busy        <= 1'b0;
      done_pend   <= 1'b0;
      load_done   <= 1'b0;
      pass        <= 1'b0;
      mode_q      <= 1'b0;
    end else begin
      ifmap_we    <= adv && (state == IFMAP);
      weight_we   <= adv && (state == WEIGHT);
      bias_we     <= adv && (state == BIAS);
      ifmap_addr  <= {mode_q & pass, cnt[IFMAP_AW-2:0]};
      weight_addr <= cnt[WEIGHT_AW-1:0];
      bias_addr   <= cnt[BIAS_AW-1:0];
      if (adv) wdata <= data_in;
      busy      <= start | adv;
      done_pend <= adv && (state == BIAS) && seg_last;
      load_done <= done_pend;
      // Toggle with load_done so a back-to-back start sees the new bank.
      if (done_pend) pass <= ~pass;
      if (start) mode_q <= mode;
    end
  end

`ifdef STREAM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum      <= '0;
      checksum <= '0;
    end else begin
      if (start)    sum <= '0;
      else if (adv) sum <= sum + data_in;
      if (done_pend) checksum <= sum;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_stream_loader.sv
// Randomized bench for stream_loader with a pass-level reference model.
module tb_stream_loader;

  localparam int NI  = 16;
  localparam int NW  = 1024;
  localparam int NB  = 64;
  localparam int TOT = NI + NW + NB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mode = 1'b0;
  logic        ready = 1'b0;
  logic [31:0] data_in = '0;
  logic        busy, ifmap_we, weight_we, bias_we;
  logic        load_done, pass;
  logic [4:0]  ifmap_addr;
  logic [9:0]  weight_addr;
  logic [5:0]  bias_addr;
  logic [31:0] wdata, checksum;

  logic        b_ready = 1'b0;
  logic [31:0] b_data = '0;
  logic        b_busy, b_iwe, b_wwe, b_bwe, b_done, b_pass;
  logic [4:0]  b_iaddr;
  logic [9:0]  b_waddr;
  logic [5:0]  b_baddr;
  logic [31:0] b_wdata, b_ck;

  always #5 clk = ~clk;

  stream_loader u_dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .ready      (ready),
    .data_in    (data_in),
    .busy       (busy),
    .ifmap_we   (ifmap_we),
    .ifmap_addr (ifmap_addr),
    .weight_we  (weight_we),
    .weight_addr(weight_addr),
    .bias_we    (bias_we),
    .bias_addr  (bias_addr),
    .wdata      (wdata),
    .load_done  (load_done),
    .pass       (pass),
    .checksum   (checksum)
  );

  stream_loader #(
    .IFMAP_WORDS (1),
    .WEIGHT_WORDS(1),
    .BIAS_WORDS  (1)
  ) u_bnd (
    .clk        (clk),
    .rst        (rst),
    .mode       (1'b0),
    .ready      (b_ready),
    .data_in    (b_data),
    .busy       (b_busy),
    .ifmap_we   (b_iwe),
    .ifmap_addr (b_iaddr),
    .weight_we  (b_wwe),
    .weight_addr(b_waddr),
    .bias_we    (b_bwe),
    .bias_addr  (b_baddr),
    .wdata      (b_wdata),
    .load_done  (b_done),
    .pass       (b_pass),
    .checksum   (b_ck)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)",
                  nm, act, exp, $time);
  endtask

  // Model: a pass is one linear run of TOT words split by index range.
  int          m_idx = -1;
  logic        m_pass, m_mode, m_pend;
  logic [31:0] m_sum;
  logic        e_iwe, e_wwe, e_bwe, e_busy, e_done;
  logic [4:0]  e_iaddr;
  logic [9:0]  e_waddr;
  logic [5:0]  e_baddr;
  logic [31:0] e_wdata, e_ck;

  always @(posedge clk) begin
    if (rst) begin
      m_idx  <= -1;
      m_pass <= 1'b0;
      m_mode <= 1'b0;
      m_pend <= 1'b0;
      m_sum  <= '0;
      e_iwe  <= 1'b0;
      e_wwe  <= 1'b0;
      e_bwe  <= 1'b0;
      e_busy <= 1'b0;
      e_done <= 1'b0;
      e_ck   <= '0;
    end else begin
      e_iwe  <= 1'b0;
      e_wwe  <= 1'b0;
      e_bwe  <= 1'b0;
      e_done <= m_pend;
      m_pend <= 1'b0;
      if (m_pend) m_pass <= ~m_pass;
`ifdef STREAM_LOADER_CHECKSUM_EN
      if (m_pend) e_ck <= m_sum;
`endif
      if (m_idx < 0) begin
        e_busy <= ready;
        if (ready) begin
          m_idx  <= 0;
          m_mode <= mode;
          m_sum  <= '0;
        end
      end else begin
        e_busy  <= 1'b1;
        e_wdata <= data_in;
        m_sum   <= m_sum + data_in;
        if (m_idx < NI) begin
          e_iwe   <= 1'b1;
          e_iaddr <= {m_mode & m_pass, 4'(m_idx)};
        end else if (m_idx < NI + NW) begin
          e_wwe   <= 1'b1;
          e_waddr <= 10'(m_idx - NI);
        end else begin
          e_bwe   <= 1'b1;
          e_baddr <= 6'(m_idx - NI - NW);
        end
        if (m_idx == TOT - 1) begin
          m_idx  <= -1;
          m_pend <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  int          o_i, o_w, o_b, o_ihi, o_done;
  logic [4:0]  first_iaddr;
  logic [31:0] first_wd, last_ck;
  logic [9:0]  last_waddr;
  logic [5:0]  last_baddr;

  task automatic clear_obs();
    o_i = 0; o_w = 0; o_b = 0; o_ihi = 0; o_done = 0;
    first_iaddr = '1;
    first_wd = '0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("load_done", 32'(load_done), 32'(e_done));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("ifmap_we", 32'(ifmap_we), 32'(e_iwe));
      chk("weight_we", 32'(weight_we), 32'(e_wwe));
      chk("bias_we", 32'(bias_we), 32'(e_bwe));
      chk("checksum", checksum, e_ck);
      if (e_iwe) chk("ifmap_addr", 32'(ifmap_addr), 32'(e_iaddr));
      if (e_wwe) chk("weight_addr", 32'(weight_addr), 32'(e_waddr));
      if (e_bwe) chk("bias_addr", 32'(bias_addr), 32'(e_baddr));
      if (e_iwe || e_wwe || e_bwe) chk("wdata", wdata, e_wdata);
      if (ifmap_we) begin
        if (o_i == 0) begin
          first_iaddr = ifmap_addr;
          first_wd    = wdata;
        end
        o_i++;
        if (ifmap_addr[4]) o_ihi++;
      end
      if (weight_we) begin o_w++; last_waddr = weight_addr; end
      if (bias_we) begin o_b++; last_baddr = bias_addr; end
      if (load_done) begin o_done++; last_ck = checksum; end
    end
  end

  function automatic logic [31:0] word(int kind, int i);
    if (kind == 0) return 32'h1000_0000 + 32'(i);
    if (kind == 2) return 32'hFFFF_FFFF;
    return $urandom;
  endfunction

  // rdy_at: index to raise ready mid-load, -2 for random noise.
  // abort_at: index after which rst is applied.
  task automatic drive_pass(input bit m, input int kind,
                            input int rdy_at, input int abort_at);
    @(negedge clk);
    ready   = 1'b1;
    mode    = m;
    data_in = $urandom;
    for (int i = 0; i < TOT; i++) begin
      @(negedge clk);
      ready = (i == rdy_at) ||
              (rdy_at == -2 && $urandom_range(0, 3) == 0);
      mode    = 1'($urandom);
      data_in = word(kind, i);
      if (i == abort_at) begin
        @(negedge clk);
        rst   = 1'b1;
        ready = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_iwe", 32'(ifmap_we), 0);
        chk("abort_wwe", 32'(weight_we), 0);
        chk("abort_bwe", 32'(bias_we), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pass", 32'(pass), 0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end
    @(negedge clk);
    ready   = 1'b0;
    data_in = $urandom;
    repeat (3) @(negedge clk);
    @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_we", 32'({ifmap_we, weight_we, bias_we}), 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ck", checksum, 0);
    chk_en = 1'b1;

    clear_obs();
    drive_pass(1'b0, 0, -1, -1);
    chk("p1_ifmap_n", o_i, NI);
    chk("p1_weight_n", o_w, NW);
    chk("p1_bias_n", o_b, NB);
    chk("p1_done_n", o_done, 1);
    chk("p1_pass", 32'(pass), 1);
    chk("p1_first_wd", first_wd, 32'h1000_0000);
    chk("p1_last_waddr", 32'(last_waddr), 1023);
    chk("p1_last_baddr", 32'(last_baddr), 63);

    clear_obs();
    drive_pass(1'b0, 1, TOT - 1, -1);
    chk("p2_ifmap_hi", o_ihi, 0);
    chk("p2_busy_idle", 32'(busy), 0);
    chk("p2_pass", 32'(pass), 0);

    clear_obs();
    drive_pass(1'b1, 1, 500, -1);
    chk("p3_writes", o_i + o_w + o_b, TOT);
    chk("p3_ifmap_hi", o_ihi, 0);
    chk("p3_done_n", o_done, 1);

    clear_obs();
    drive_pass(1'b1, 1, -1, NI + 300);
    chk("p4_ifmap_hi", o_ihi, NI);
    chk("p4_weight_n", o_w, 301);
    chk("p4_done_n", o_done, 0);

    clear_obs();
    drive_pass(1'b1, 2, -1, -1);
    chk("p5_first_iaddr", 32'(first_iaddr), 0);
    chk("p5_ifmap_hi", o_ihi, 0);
`ifdef STREAM_LOADER_CHECKSUM_EN
    chk("p5_checksum", last_ck, 32'hFFFF_FBB0);
`else
    chk("p5_checksum", last_ck, 0);
`endif

    clear_obs();
    drive_pass(1'b1, 1, -2, -1);
    chk("p6_ifmap_hi", o_ihi, NI);
    chk("p6_done_n", o_done, 1);

    @(negedge clk);
    b_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("b_busy0", 32'(b_busy), 1);
    @(negedge clk);
    b_ready = 1'b0;
    b_data  = 32'hAAAA_0001;
    @(posedge clk);
    #1;
    chk("b_iwe", 32'(b_iwe), 1);
    chk("b_iaddr", 32'(b_iaddr), 0);
    chk("b_wd_a", b_wdata, 32'hAAAA_0001);
    @(negedge clk);
    b_data = 32'hBBBB_0002;
    @(posedge clk);
    #1;
    chk("b_wwe", 32'({b_iwe, b_wwe, b_bwe}), 32'b010);
    chk("b_waddr", 32'(b_waddr), 0);
    chk("b_wd_b", b_wdata, 32'hBBBB_0002);
    @(negedge clk);
    b_data = 32'hCCCC_0003;
    @(posedge clk);
    #1;
    chk("b_bwe", 32'({b_iwe, b_wwe, b_bwe}), 32'b001);
    chk("b_baddr", 32'(b_baddr), 0);
    chk("b_wd_c", b_wdata, 32'hCCCC_0003);
    chk("b_busy3", 32'(b_busy), 1);
    @(posedge clk);
    #1;
    chk("b_done", 32'(b_done), 1);
    chk("b_busy4", 32'(b_busy), 0);
    chk("b_we4", 32'({b_iwe, b_wwe, b_bwe}), 0);
    @(posedge clk);
    #1;
    chk("b_done_off", 32'(b_done), 0);
    chk("b_pass", 32'(b_pass), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
